// File: rtl/result_capture_pkg.sv
// Shared constants and types for the result capture path.
package result_capture_pkg;
  localparam int RC_DATA_W = 32;
  localparam int RC_DEPTH  = 8;
  localparam int RC_CNT_W  = 16;

  typedef logic [RC_DATA_W-1:0] rc_word_t;
endpackage

// File: rtl/result_capture_fifo_if.sv
// Capture input bus plus the drained valid/ready stream and status.
interface result_capture_fifo_if
  import result_capture_pkg::*;
#(
  parameter int DATA_W = RC_DATA_W,
  parameter int DEPTH  = RC_DEPTH,
  parameter int CNT_W  = RC_CNT_W
);
  logic [DATA_W-1:0]        result_in;
  logic                     capture_en;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic [CNT_W-1:0]         overflow_cnt;

  modport master (
    output result_in, capture_en, out_ready,
    input  out_data, out_valid, count, full, overflow_cnt
  );

  modport slave (
    input  result_in, capture_en, out_ready,
    output out_data, out_valid, count, full, overflow_cnt
  );
endinterface

// File: rtl/result_capture_fifo_sync_fifo.sv
// Generic synchronous FIFO, first-word fall-through read of mem[rd_ptr].
// Reset clears storage so the head reads zero while empty.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
endmodule

// File: rtl/result_capture_fifo.sv
// Samples the processor result bus, queues each changed value, drains via valid/ready.
// Values arriving while the queue is full and not draining are counted as drops.
module result_capture_fifo
  import result_capture_pkg::*;
#(
  parameter int DATA_W = RC_DATA_W,
  parameter int DEPTH  = RC_DEPTH,
  parameter int CNT_W  = RC_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  result_capture_fifo_if.slave bus
);
  logic [DATA_W-1:0]      last_val_q, last_val_d;
  logic                   armed_q, armed_d;
  logic [CNT_W-1:0]       ovf_q, ovf_d;
  logic                   cap_req, push, pop, drop;
  logic [DATA_W-1:0]      fifo_rd_data;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full, fifo_empty;

  // An unarmed detector captures even a value equal to the cleared last_val.
  assign cap_req = bus.capture_en && (!armed_q || (bus.result_in != last_val_q));
  assign pop     = !fifo_empty && bus.out_ready;
  assign push    = cap_req && (!fifo_full || pop);
  assign drop    = cap_req && fifo_full && !pop;

  always_comb begin
    last_val_d = last_val_q;
    armed_d    = armed_q;
    ovf_d      = ovf_q;
    if (bus.capture_en) begin
      last_val_d = bus.result_in;
      armed_d    = 1'b1;
    end
    if (drop && (ovf_q != '1)) begin
      ovf_d = ovf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_val_q <= '0;
      armed_q    <= 1'b0;
      ovf_q      <= '0;
    end else begin
      last_val_q <= last_val_d;
      armed_q    <= armed_d;
      ovf_q      <= ovf_d;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (bus.result_in),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.out_data     = fifo_rd_data;
  assign bus.out_valid    = !fifo_empty;
  assign bus.count        = fifo_count;
  assign bus.full         = fifo_full;
  assign bus.overflow_cnt = ovf_q;
endmodule

// File: tb/tb_result_capture_fifo.sv
// Directed bench for result_capture_fifo: default instance plus a CNT_W=2 instance.
module tb_result_capture_fifo;
  import result_capture_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  result_capture_fifo_if #(.DATA_W(32), .DEPTH(8), .CNT_W(16)) bus ();
  result_capture_fifo_if #(.DATA_W(32), .DEPTH(8), .CNT_W(2))  sbus ();

  result_capture_fifo #(.DATA_W(32), .DEPTH(8), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  result_capture_fifo #(.DATA_W(32), .DEPTH(8), .CNT_W(2)) u_sat (
    .clk   (clk),
    .reset (rst_n),
    .bus   (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are read 1 time unit after it, inputs driven there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  rc_word_t cd_in   [6] = '{32'd5, 32'd5, 32'd7, 32'd7, 32'd7, 32'd9};
  logic     cd_vld  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.result_in = '0;  bus.capture_en = 1'b0;  bus.out_ready = 1'b0;
    sbus.result_in = '0; sbus.capture_en = 1'b0; sbus.out_ready = 1'b0;

    // Reset holds everything clear regardless of inputs
    for (int i = 0; i < 3; i++) begin
      bus.result_in  = $urandom;
      bus.capture_en = 1'($urandom_range(0, 1));
      bus.out_ready  = 1'($urandom_range(0, 1));
      step();
      check("rst_valid", 64'(bus.out_valid), 64'd0);
      check("rst_count", 64'(bus.count), 64'd0);
      check("rst_ovf", 64'(bus.overflow_cnt), 64'd0);
      check("rst_data", 64'(bus.out_data), 64'd0);
    end
    check("rst_full", 64'(bus.full), 64'd0);

    // First enabled cycle captures zero
    rst_n = 1'b1;
    bus.capture_en = 1'b1; bus.result_in = 32'd0; bus.out_ready = 1'b0;
    step();
    check("first_valid", 64'(bus.out_valid), 64'd1);
    check("first_count", 64'(bus.count), 64'd1);
    check("first_data", 64'(bus.out_data), 64'd0);
    bus.capture_en = 1'b0; bus.out_ready = 1'b1;
    step();
    check("first_drain", 64'(bus.count), 64'd0);

    // Change detection with a ready consumer
    bus.capture_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.result_in = cd_in[i];
      step();
      check($sformatf("cd_valid%0d", i), 64'(bus.out_valid), 64'(cd_vld[i]));
      if (cd_vld[i]) check($sformatf("cd_data%0d", i), 64'(bus.out_data), 64'(cd_in[i]));
    end
    bus.capture_en = 1'b0; bus.result_in = 32'd11;
    step();
    step();
    check("dis_valid", 64'(bus.out_valid), 64'd0);
    check("dis_count", 64'(bus.count), 64'd0);

    // Fill with 1..10, two drops
    bus.out_ready = 1'b0; bus.capture_en = 1'b1;
    for (int v = 1; v <= 10; v++) begin
      bus.result_in = 32'(v);
      step();
    end
    check("fill_count", 64'(bus.count), 64'd8);
    check("fill_full", 64'(bus.full), 64'd1);
    check("fill_ovf", 64'(bus.overflow_cnt), 64'd2);
    check("fill_head", 64'(bus.out_data), 64'd1);
    bus.capture_en = 1'b0; bus.out_ready = 1'b1;
    for (int v = 1; v <= 8; v++) begin
      check($sformatf("drain%0d", v), 64'(bus.out_data), 64'(v));
      step();
    end
    check("drain_count", 64'(bus.count), 64'd0);
    check("drain_valid", 64'(bus.out_valid), 64'd0);

    // Simultaneous push and pop while full
    bus.out_ready = 1'b0; bus.capture_en = 1'b1;
    for (int v = 16; v < 24; v++) begin
      bus.result_in = 32'(v);
      step();
    end
    check("pp_prefull", 64'(bus.count), 64'd8);
    bus.out_ready = 1'b1; bus.result_in = 32'hAA;
    step();
    check("pp_count", 64'(bus.count), 64'd8);
    check("pp_ovf", 64'(bus.overflow_cnt), 64'd2);
    bus.capture_en = 1'b0;
    for (int v = 17; v < 24; v++) begin
      check($sformatf("pp_drain%0d", v), 64'(bus.out_data), 64'(v));
      step();
    end
    check("pp_last", 64'(bus.out_data), 64'hAA);
    step();
    check("pp_empty", 64'(bus.count), 64'd0);

    // Saturating 2-bit drop counter
    sbus.out_ready = 1'b0; sbus.capture_en = 1'b1;
    for (int v = 100; v < 110; v++) begin
      sbus.result_in = 32'(v);
      step();
    end
    check("sat_two", 64'(sbus.overflow_cnt), 64'd2);
    sbus.result_in = 32'd110;
    step();
    check("sat_three", 64'(sbus.overflow_cnt), 64'd3);
    for (int v = 111; v < 114; v++) begin
      sbus.result_in = 32'(v);
      step();
    end
    check("sat_hold", 64'(sbus.overflow_cnt), 64'd3);
    check("sat_count", 64'(sbus.count), 64'd8);
    sbus.capture_en = 1'b0;

    // Reset between edges with four entries queued
    bus.out_ready = 1'b0; bus.capture_en = 1'b1;
    for (int v = 33; v < 37; v++) begin
      bus.result_in = 32'(v);
      step();
    end
    check("mid_pre", 64'(bus.count), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_count", 64'(bus.count), 64'd0);
    check("mid_valid", 64'(bus.out_valid), 64'd0);
    check("mid_data", 64'(bus.out_data), 64'd0);
    check("mid_ovf", 64'(bus.overflow_cnt), 64'd0);
    check("mid_sat_ovf", 64'(sbus.overflow_cnt), 64'd0);
    step();
    rst_n = 1'b1;
    bus.result_in = 32'd36;
    step();
    check("rearm_valid", 64'(bus.out_valid), 64'd1);
    check("rearm_data", 64'(bus.out_data), 64'd36);
    check("rearm_count", 64'(bus.count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
